// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter, plus a reference decoder
// used by the testbench to cross-check the registered Gray output.
package gray_pkg;

    typedef enum logic {
        GC_WRAP = 1'b0,
        GC_SAT  = 1'b1
    } gc_mode_e;

    localparam int GC_MAX_WIDTH = 16;

    // Binary is the XOR of all right shifts of the Gray word; any width up
    // to GC_MAX_WIDTH works as long as unused upper bits are zero.
    function automatic logic [GC_MAX_WIDTH-1:0] gray2bin(input logic [GC_MAX_WIDTH-1:0] g);
        logic [GC_MAX_WIDTH-1:0] b;
        b = g;
        for (int k = 1; k < GC_MAX_WIDTH; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle for gray_counter; the master drives the
// count controls, the slave (the counter) returns the count state.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             tc;
    logic             wrapped;

    modport master (
        output en, up, load, load_bin,
        input  bin, gray, tc, wrapped
    );

    modport slave (
        input  en, up, load, load_bin,
        output bin, gray, tc, wrapped
    );
endinterface

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder; the MSB passes through unchanged.
module gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror, load,
// terminal-count decode and wrap or saturate behaviour at the ends.
module gray_counter
    import gray_pkg::*;
#(
    parameter int       WIDTH = 4,
    parameter gc_mode_e MODE  = GC_WRAP
) (
    input  logic          clk,
    input  logic          rst,
    gray_counter_if.slave bus
);
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrapped_q, wrapped_d;
    logic             tc;

    assign tc = bus.up ? (&bin_q) : ~(|bin_q);

    always_comb begin
        bin_d     = bin_q;
        wrapped_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en) begin
            if (tc) begin
                // At the end of the range: either roll over or stay put.
                if (MODE == GC_WRAP) begin
                    bin_d     = bus.up ? '0 : '1;
                    wrapped_d = 1'b1;
                end
            end else begin
                bin_d = bus.up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
            end
        end
    end

    // Encode the next binary value so gray_q lands on the same edge as bin_q.
    gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q     <= '0;
            gray_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.bin     = bin_q;
    assign bus.gray    = gray_q;
    assign bus.tc      = tc;
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: one wrapping and one saturating
// instance at WIDTH=4, checked against hand-computed vectors.
module tb_gray_counter;
    import gray_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    gray_counter_if #(.WIDTH(4)) if_w ();
    gray_counter_if #(.WIDTH(4)) if_s ();

    gray_counter #(.WIDTH(4), .MODE(GC_WRAP)) dut_w (.clk(clk), .rst(rst), .bus(if_w));
    gray_counter #(.WIDTH(4), .MODE(GC_SAT))  dut_s (.clk(clk), .rst(rst), .bus(if_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray codes after steps 1..16 counting up from 0.
    logic [3:0] exp_up [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_w.up = 1'b1;
        #1;
        n_cmp++; if (if_w.bin !== 4'b0000) begin n_bad++; $display("FAIL rst_bin: got %b want 0000", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b0000) begin n_bad++; $display("FAIL rst_gray: got %b want 0000", if_w.gray); end
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL rst_wrapped: got %b want 0", if_w.wrapped); end
        n_cmp++; if (if_w.tc !== 1'b0) begin n_bad++; $display("FAIL rst_tc_up: got %b want 0", if_w.tc); end
        if_w.up = 1'b0;
        #1;
        n_cmp++; if (if_w.tc !== 1'b1) begin n_bad++; $display("FAIL rst_tc_down: got %b want 1", if_w.tc); end
        n_cmp++; if (if_s.bin !== 4'b0000) begin n_bad++; $display("FAIL rst_sat_bin: got %b want 0000", if_s.bin); end
        @(posedge clk);
        #1;
        n_cmp++; if (if_w.bin !== 4'b0000) begin n_bad++; $display("FAIL rst_held: got %b want 0000", if_w.bin); end
        rst = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] prev;
        prev = if_w.gray;
        if_w.up = 1'b1;
        if_w.en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++; if (if_w.gray !== exp_up[i-1]) begin n_bad++; $display("FAIL up_gray step %0d: got %b want %b", i, if_w.gray, exp_up[i-1]); end
            n_cmp++; if (if_w.bin !== 4'(i)) begin n_bad++; $display("FAIL up_bin step %0d: got %b want %b", i, if_w.bin, 4'(i)); end
            n_cmp++; if (if_w.wrapped !== (i == 16)) begin n_bad++; $display("FAIL up_wrapped step %0d: got %b want %b", i, if_w.wrapped, (i == 16)); end
            n_cmp++; if (if_w.tc !== (i == 15)) begin n_bad++; $display("FAIL up_tc step %0d: got %b want %b", i, if_w.tc, (i == 15)); end
            n_cmp++; if ($countones(if_w.gray ^ prev) != 1) begin n_bad++; $display("FAIL up_onebit step %0d: got %b->%b want one bit", i, prev, if_w.gray); end
            n_cmp++; if (gray2bin(16'(if_w.gray)) !== 16'(i % 16)) begin n_bad++; $display("FAIL up_decode step %0d: got %0d want %0d", i, gray2bin(16'(if_w.gray)), i % 16); end
            prev = if_w.gray;
        end
        if_w.en = 1'b0;
        tick();
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL hold_wrapped: got %b want 0", if_w.wrapped); end
        n_cmp++; if (if_w.bin !== 4'b0000) begin n_bad++; $display("FAIL hold_bin: got %b want 0000", if_w.bin); end
    endtask

    task automatic test_down_wrap();
        if_w.up = 1'b0;
        #1;
        n_cmp++; if (if_w.tc !== 1'b1) begin n_bad++; $display("FAIL dn_tc: got %b want 1", if_w.tc); end
        if_w.en = 1'b1;
        tick();
        n_cmp++; if (if_w.bin !== 4'b1111) begin n_bad++; $display("FAIL dn_wrap_bin: got %b want 1111", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b1000) begin n_bad++; $display("FAIL dn_wrap_gray: got %b want 1000", if_w.gray); end
        n_cmp++; if (if_w.wrapped !== 1'b1) begin n_bad++; $display("FAIL dn_wrap_pulse: got %b want 1", if_w.wrapped); end
        tick();
        n_cmp++; if (if_w.bin !== 4'b1110) begin n_bad++; $display("FAIL dn_bin: got %b want 1110", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b1001) begin n_bad++; $display("FAIL dn_gray: got %b want 1001", if_w.gray); end
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL dn_wrapped: got %b want 0", if_w.wrapped); end
        // Direction reversal takes effect on the very next edge.
        if_w.up = 1'b1;
        tick();
        n_cmp++; if (if_w.bin !== 4'b1111) begin n_bad++; $display("FAIL rev_up_bin: got %b want 1111", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b1000) begin n_bad++; $display("FAIL rev_up_gray: got %b want 1000", if_w.gray); end
        if_w.up = 1'b0;
        tick();
        n_cmp++; if (if_w.bin !== 4'b1110) begin n_bad++; $display("FAIL rev_dn_bin: got %b want 1110", if_w.bin); end
        if_w.en = 1'b0;
    endtask

    task automatic test_load();
        if_w.load = 1'b1;
        if_w.load_bin = 4'b1101;
        if_w.en = 1'b1;
        if_w.up = 1'b1;
        tick();
        n_cmp++; if (if_w.bin !== 4'b1101) begin n_bad++; $display("FAIL load_bin: got %b want 1101", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b1011) begin n_bad++; $display("FAIL load_gray: got %b want 1011", if_w.gray); end
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL load_wrapped: got %b want 0", if_w.wrapped); end
        // Load from the wrap point must not raise wrapped.
        if_w.load_bin = 4'b1111;
        tick();
        if_w.load_bin = 4'b0000;
        tick();
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL load_nowrap: got %b want 0", if_w.wrapped); end
        n_cmp++; if (if_w.bin !== 4'b0000) begin n_bad++; $display("FAIL load_zero: got %b want 0000", if_w.bin); end
        if_w.load = 1'b0;
        if_w.en = 1'b0;
    endtask

    task automatic test_sat();
        if_s.load = 1'b1;
        if_s.load_bin = 4'b1111;
        tick();
        if_s.load = 1'b0;
        if_s.en = 1'b1;
        if_s.up = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (if_s.bin !== 4'b1111) begin n_bad++; $display("FAIL sat_bin step %0d: got %b want 1111", i, if_s.bin); end
            n_cmp++; if (if_s.gray !== 4'b1000) begin n_bad++; $display("FAIL sat_gray step %0d: got %b want 1000", i, if_s.gray); end
            n_cmp++; if (if_s.tc !== 1'b1) begin n_bad++; $display("FAIL sat_tc step %0d: got %b want 1", i, if_s.tc); end
            n_cmp++; if (if_s.wrapped !== 1'b0) begin n_bad++; $display("FAIL sat_wrapped step %0d: got %b want 0", i, if_s.wrapped); end
        end
        if_s.up = 1'b0;
        #1;
        n_cmp++; if (if_s.tc !== 1'b0) begin n_bad++; $display("FAIL sat_tc_down: got %b want 0", if_s.tc); end
        tick();
        n_cmp++; if (if_s.bin !== 4'b1110) begin n_bad++; $display("FAIL sat_down_bin: got %b want 1110", if_s.bin); end
        n_cmp++; if (if_s.gray !== 4'b1001) begin n_bad++; $display("FAIL sat_down_gray: got %b want 1001", if_s.gray); end
        // Saturation at the bottom end.
        if_s.en = 1'b0;
        if_s.load = 1'b1;
        if_s.load_bin = 4'b0000;
        tick();
        if_s.load = 1'b0;
        if_s.en = 1'b1;
        tick();
        n_cmp++; if (if_s.bin !== 4'b0000) begin n_bad++; $display("FAIL sat_low_bin: got %b want 0000", if_s.bin); end
        n_cmp++; if (if_s.wrapped !== 1'b0) begin n_bad++; $display("FAIL sat_low_wrapped: got %b want 0", if_s.wrapped); end
        if_s.en = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] prev;
        prev = if_w.gray;
        if_w.up = 1'b1;
        if_w.en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++; if ($countones(if_w.gray ^ prev) != 1) begin n_bad++; $display("FAIL ar_onebit step %0d: got %b->%b want one bit", i, prev, if_w.gray); end
            prev = if_w.gray;
        end
        n_cmp++; if (if_w.bin !== 4'b0110) begin n_bad++; $display("FAIL ar_pre_bin: got %b want 0110", if_w.bin); end
        rst = 1'b1;
        #1;
        n_cmp++; if (if_w.bin !== 4'b0000) begin n_bad++; $display("FAIL ar_bin: got %b want 0000", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b0000) begin n_bad++; $display("FAIL ar_gray: got %b want 0000", if_w.gray); end
        rst = 1'b0;
        tick();
        n_cmp++; if (if_w.bin !== 4'b0001) begin n_bad++; $display("FAIL ar_first_bin: got %b want 0001", if_w.bin); end
        n_cmp++; if (if_w.gray !== 4'b0001) begin n_bad++; $display("FAIL ar_first_gray: got %b want 0001", if_w.gray); end
        // A reset landing on a wrapped pulse must cancel it.
        if_w.en = 1'b0;
        if_w.load = 1'b1;
        if_w.load_bin = 4'b1111;
        tick();
        if_w.load = 1'b0;
        if_w.en = 1'b1;
        tick();
        n_cmp++; if (if_w.wrapped !== 1'b1) begin n_bad++; $display("FAIL ar_wrap_pulse: got %b want 1", if_w.wrapped); end
        if_w.en = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL ar_wrap_cleared: got %b want 0", if_w.wrapped); end
        rst = 1'b0;
        tick();
        n_cmp++; if (if_w.wrapped !== 1'b0) begin n_bad++; $display("FAIL ar_wrap_after: got %b want 0", if_w.wrapped); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        if_w.en = 1'b0; if_w.up = 1'b1; if_w.load = 1'b0; if_w.load_bin = '0;
        if_s.en = 1'b0; if_s.up = 1'b1; if_s.load = 1'b0; if_s.load_bin = '0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter and code width in bits; legal range 2..16.
REQ-002 Parameter MODE, default GC_WRAP: GC_WRAP = wrap at terminal count; GC_SAT = saturate at terminal count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_bin  input  WIDTH  binary value captured on load.
REQ-009 bin  output  WIDTH  registered binary count.
REQ-010 gray  output  WIDTH  registered Gray code of bin.
REQ-011 tc  output  1  terminal count: high when bin is at the terminal value for the current up.
REQ-012 wrapped  output  1  one-cycle pulse after a step that wrapped.

Function
REQ-013 gray SHALL equal bin XOR (bin >> 1) at every cycle; bit WIDTH-1 of gray SHALL equal bit WIDTH-1 of bin.
REQ-014 gray SHALL be driven from a register, not from combinational decode of bin; it SHALL update on the same edge as bin (zero extra latency).
REQ-015 Priority per edge: load, then en, then hold.
REQ-016 On load=1, bin SHALL take load_bin and gray SHALL take its Gray encoding on the next edge; wrapped SHALL be 0 on that cycle; en and up are ignored.
REQ-017 On en=1, load=0, up=1: bin SHALL become bin+1 modulo 2^WIDTH in GC_WRAP mode.
REQ-018 On en=1, load=0, up=0: bin SHALL become bin-1 modulo 2^WIDTH in GC_WRAP mode.
REQ-019 tc SHALL be combinational from the bin register and up: 1 if (up=1 and bin=all ones) or (up=0 and bin=0); otherwise 0.
REQ-020 In GC_WRAP mode, a step taken with tc=1 SHALL wrap (all ones to 0 up, 0 to all ones down), and wrapped SHALL be 1 for exactly the following cycle.
REQ-021 In GC_SAT mode, a step taken with tc=1 SHALL leave bin and gray unchanged; wrapped SHALL stay 0.
REQ-022 A direction change with en=1 SHALL take effect on the same edge, with no dead cycle.
REQ-023 Successive gray values across any en-step SHALL differ in exactly one bit, including the wrap step. Load steps and saturated holds are exempt.
REQ-024 With en=0 and load=0, all registers SHALL hold, and wrapped SHALL return to 0.

Reset
REQ-025 While rst=1, bin, gray and wrapped SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 rst asserted mid-count SHALL abandon the count and discard any pending wrapped pulse.
REQ-027 The first edge after rst deasserts SHALL act on en, up and load normally.
REQ-028 tc SHALL follow REQ-019 during reset: it is 1 if up=0 and 0 if up=1.

Structure
REQ-029 Package gray_pkg SHALL hold the MODE constants GC_WRAP=0 and GC_SAT=1.
REQ-030 Package gray_pkg SHALL also hold a WIDTH-generic gray-to-binary reference function, used only by the bench.
REQ-031 Sub-module gray_enc SHALL be instantiated once: a WIDTH-parametrised combinational binary-to-Gray encoder that feeds the gray register's next-state.
REQ-032 The binary next-state logic and the tc decode SHALL reside in gray_counter.

Verification (WIDTH=4)
REQ-033 Reset: rst=1, up=1 -> bin=0000, gray=0000, wrapped=0, tc=0; with up=0 -> tc=1.
REQ-034 Up wrap, GC_WRAP: 16 enabled steps from 0 -> gray 0000,0001,0011,0010,0110,...,1000; the 1111->0000 step gives gray 1000->0000 and wrapped=1 for one cycle.
REQ-035 Down wrap, GC_WRAP: up=0, en=1 at bin=0000 -> bin=1111, gray=1000, wrapped=1; the next step gives bin=1110, gray=1001, wrapped=0.
REQ-036 Load priority: load=1, load_bin=1101, en=1, up=1 -> bin=1101, gray=1011, wrapped=0.
REQ-037 Saturate, GC_SAT: load 1111, then 3 up steps -> bin stays 1111, gray stays 1000, tc=1, wrapped=0; up=0 -> tc=0, and the next step gives bin=1110.
REQ-038 Async reset mid-count: rst pulsed between edges at bin=0110 -> outputs read 0 before the next edge; the bench checks one-bit gray transitions on every step throughout.
